// File: rtl/seqcheck_multi.sv
// Multi-channel sliding-window edge monitor: counts qualifying edges over the last W
// enabled cycles per channel and pulses hit on threshold crossing. Optional: SEQMON_STICKY_EN.
module seqcheck_multi #(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CW   = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [1:0]           edge_mode,
    input  logic [CW-1:0]        threshold,
    input  logic [N_CH-1:0]      in_sig,
    output logic [N_CH-1:0]      hit,
    output logic [N_CH*CW-1:0]   count
`ifdef SEQMON_STICKY_EN
    ,
    output logic [N_CH-1:0]      hit_sticky,
    input  logic [N_CH-1:0]      sticky_clr
`endif
);

    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] met;
    logic [N_CH-1:0] met_nx;
    logic [W-1:0]    win    [N_CH];
    logic [CW-1:0]   cnt    [N_CH];
    logic [CW-1:0]   cnt_nx [N_CH];

    always_comb begin
        ev    = '0;
        count = '0;
        case (edge_mode)
            2'b00:   ev = in_sig & ~prev;
            2'b01:   ev = ~in_sig & prev;
            2'b10:   ev = in_sig ^ prev;
            default: ev = '0;
        endcase
        for (int unsigned i = 0; i < N_CH; i++) begin
            // Oldest bit leaves as the new one enters, so the sum stays within 0..W.
            cnt_nx[i] = cnt[i] + CW'(ev[i]) - CW'(win[i][W-1]);
            met_nx[i] = (threshold != '0) && (cnt_nx[i] >= threshold);
            count[i*CW +: CW] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            met  <= '0;
            hit  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                win[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            // prev follows the input even while disabled so re-enable sees no stale edge.
            prev <= in_sig;
            if (clear) begin
                met <= '0;
                hit <= '0;
                for (int unsigned i = 0; i < N_CH; i++) begin
                    win[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (en) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    win[i] <= {win[i][W-2:0], ev[i]};
                    cnt[i] <= cnt_nx[i];
                end
                met <= met_nx;
                hit <= met_nx & ~met;
            end else begin
                hit <= '0;
            end
        end
    end

`ifdef SEQMON_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst)
            hit_sticky <= '0;
        else
            hit_sticky <= (hit_sticky & ~sticky_clr) | hit;
    end
`else
    // Sticky flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_seqcheck_multi.sv
// Scoreboard bench for seqcheck_multi: a window-history reference model predicts every
// cycle's outputs, a monitor compares them; directed scenarios followed by random traffic.
module tb_seqcheck_multi;
    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CW   = $clog2(W + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                clear = 1'b0;
    logic [1:0]          edge_mode = 2'b00;
    logic [CW-1:0]       threshold = '0;
    logic [N_CH-1:0]     in_sig = '0;
    logic [N_CH-1:0]     hit;
    logic [N_CH*CW-1:0]  count;
    logic [N_CH-1:0]     sticky_clr = '0;
`ifdef SEQMON_STICKY_EN
    logic [N_CH-1:0]     hit_sticky;
`endif

    always #5 clk = ~clk;

    seqcheck_multi #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .edge_mode(edge_mode),
        .threshold(threshold), .in_sig(in_sig), .hit(hit), .count(count)
`ifdef SEQMON_STICKY_EN
        , .hit_sticky(hit_sticky), .sticky_clr(sticky_clr)
`endif
    );

    typedef struct {
        logic [N_CH-1:0]    hit;
        logic [N_CH*CW-1:0] count;
        logic [N_CH-1:0]    sticky;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   hits_seen [N_CH];

    // Reference model: per channel the literal list of the last W enabled-cycle edge flags.
    bit              hist [N_CH][$];
    bit              above [N_CH];
    logic [N_CH-1:0] m_hit, m_prev, m_sticky;
    logic [1:0]      cur_mode = 2'b00;
    logic [CW-1:0]   cur_thr = '0;

    function automatic void check(string name, longint unsigned act, longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int wsum(int ch);
        int s = 0;
        foreach (hist[ch][k]) s += int'(hist[ch][k]);
        return s;
    endfunction

    function automatic void wipe_windows();
        for (int ch = 0; ch < N_CH; ch++) begin
            hist[ch].delete();
            for (int k = 0; k < W; k++) hist[ch].push_back(1'b0);
            above[ch] = 1'b0;
        end
        m_hit = '0;
    endfunction

    function automatic void model_step(logic r, logic c, logic e, logic [1:0] mode,
                                       logic [CW-1:0] thr, logic [N_CH-1:0] in, logic [N_CH-1:0] sclr);
        exp_t x;
        bit   evb;
        int   s;
        bit   now;
        if (r) begin
            wipe_windows();
            m_prev   = '0;
            m_sticky = '0;
        end else begin
            m_sticky = (m_sticky & ~sclr) | m_hit;
            for (int ch = 0; ch < N_CH; ch++) begin
                case (mode)
                    2'd0: evb = in[ch] && !m_prev[ch];
                    2'd1: evb = !in[ch] && m_prev[ch];
                    2'd2: evb = in[ch] != m_prev[ch];
                    default: evb = 1'b0;
                endcase
                if (!c && e) begin
                    void'(hist[ch].pop_front());
                    hist[ch].push_back(evb);
                    s   = wsum(ch);
                    now = (thr != 0) && (s >= int'(thr));
                    m_hit[ch] = now && !above[ch];
                    above[ch] = now;
                end else if (!c) begin
                    m_hit[ch] = 1'b0;
                end
            end
            if (c) wipe_windows();
            m_prev = in;
        end
        x.hit    = m_hit;
        x.sticky = m_sticky;
        x.count  = '0;
        for (int ch = 0; ch < N_CH; ch++) x.count[ch*CW +: CW] = CW'(wsum(ch));
        sb.push_back(x);
    endfunction

    task automatic drive(logic r, logic c, logic e, logic [N_CH-1:0] in, logic [N_CH-1:0] sclr);
        @(negedge clk);
        rst = r; clear = c; en = e; in_sig = in; sticky_clr = sclr;
        edge_mode = cur_mode; threshold = cur_thr;
        model_step(r, c, e, cur_mode, cur_thr, in, sclr);
    endtask

    task automatic step(logic [N_CH-1:0] in);
        drive(1'b0, 1'b0, 1'b1, in, '0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CW-1:0] cnt_of(int ch);
        logic [N_CH*CW-1:0] v;
        v = count;
        return v[ch*CW +: CW];
    endfunction

    function automatic void zero_hits();
        for (int ch = 0; ch < N_CH; ch++) hits_seen[ch] = 0;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hit", hit, e.hit);
                check("count", count, e.count);
`ifdef SEQMON_STICKY_EN
                check("hit_sticky", hit_sticky, e.sticky);
`endif
                for (int ch = 0; ch < N_CH; ch++) if (hit[ch]) hits_seen[ch]++;
            end
        end
    end

    initial begin
        int g;
        logic [N_CH-1:0] sc;
        m_prev = '0; m_sticky = '0;
        wipe_windows();
        zero_hits();

        // Reset with toggling inputs.
        drive(1'b1, 1'b0, 1'b1, 4'b1010, '0);
        drive(1'b1, 1'b0, 1'b1, 4'b0101, '0);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, '0);

        // Rise mode, thr=3, ch0 pulses every other cycle.
        cur_mode = 2'd0; cur_thr = CW'(3);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, '0);
        settle(); zero_hits();
        for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 4'b0001 : 4'b0000);
        settle();
        check("t2_count3", cnt_of(0), 3);
        check("t2_one_hit", hits_seen[0], 1);
        for (int k = 0; k < 4; k++) step((k % 2 == 0) ? 4'b0001 : 4'b0000);
        settle();
        check("t2_no_rehit", hits_seen[0], 1);
        for (int k = 0; k < 10; k++) step(4'b0000);

        // Both edges, thr=4, ch1 toggles then decays.
        cur_mode = 2'd2; cur_thr = CW'(4);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, '0);
        settle(); zero_hits();
        for (int k = 0; k < 4; k++) step((k % 2 == 0) ? 4'b0010 : 4'b0000);
        for (int k = 0; k < 8; k++) step(4'b0000);
        settle();
        check("t3_hit_ch1", hits_seen[1], 1);
        check("t3_hit_ch0", hits_seen[0], 0);
        check("t3_decay", cnt_of(1), 0);

        // Enable hold and no spurious edge on re-enable.
        cur_mode = 2'd0; cur_thr = CW'(3);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, '0);
        for (int k = 0; k < 5; k++) step((k % 2 == 0) ? 4'b0001 : 4'b0000);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 4'b0001, '0);
        settle();
        check("t4_held", cnt_of(0), 3);
        check("t4_hit_low", hit, 0);
        step(4'b0001);
        settle();
        check("t4_reenable", cnt_of(0), 3);

        // Clear with concurrent edge.
        drive(1'b0, 1'b1, 1'b1, 4'b0000, '0);
        for (int k = 0; k < 4; k++) step((k % 2 == 0) ? 4'b0001 : 4'b0000);
        drive(1'b0, 1'b1, 1'b1, 4'b0001, '0);
        settle();
        check("t5_clr_count", cnt_of(0), 0);
        check("t5_clr_hit", hit[0], 0);

`ifdef SEQMON_STICKY_EN
        // Sticky flag set/clear interplay on ch2.
        cur_mode = 2'd0; cur_thr = CW'(1);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111);
        step(4'b0100);
        step(4'b0000);
        settle();
        check("t6_sticky_set", hit_sticky[2], 1);
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
        settle();
        check("t6_sticky_clr", hit_sticky[2], 0);
        for (int k = 0; k < 8; k++) step(4'b0000);
        step(4'b0100);
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
        settle();
        check("t6_set_wins", hit_sticky[2], 1);
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
        settle();
        check("t6_clr_alone", hit_sticky[2], 0);
`endif

        // Random traffic including thr=0 and thr>W.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) cur_thr = CW'($urandom_range(0, W + 2));
            sc = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 8, N_CH'($urandom), sc);
        end

        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(posedge clk);
            #3;
            g++;
        end
        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
